// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and widths for the UART transmit arbiter
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  localparam int LEN_W = 16;
  typedef enum logic {IDLE, XFER} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last_i, wrapping to 0
module rr_arbiter #(
  parameter int N = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  output logic [GW-1:0] idx_o,
  output logic          any_o
);
  assign any_o = |req_i;
  always_comb begin : pick
    logic [GW-1:0] j;
    j = '0;
    idx_o = last_i;
    // descending scan so the nearest requester after last_i is written last and wins
    for (int k = N; k >= 1; k--) begin
      j = GW'((int'(last_i) + k) % N);
      idx_o = req_i[j] ? j : idx_o;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between byte-stream requesters.
// Define UART_TX_ARB_STATS_EN to enable the per-requester completed-message counters on msg_count.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_MSG_LEN = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [BYTE_W-1:0]          tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       overrun,
  output logic [LEN_W*NUM_REQ-1:0]   msg_count
);
  localparam int GW = $clog2(NUM_REQ);
  state_e state_q;
  logic [GW-1:0] grant_q, last_q, win;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic overrun_q, any, fire, done;
  rr_arbiter #(.N(NUM_REQ), .GW(GW)) u_rr (
    .req_i  (req_valid),
    .last_i (last_q),
    .idx_o  (win),
    .any_o  (any)
  );
  assign busy = state_q == XFER;
  assign tx_valid = busy && req_valid[grant_q];
  assign tx_data = req_data[grant_q*BYTE_W +: BYTE_W];
  assign req_ready = (busy && tx_ready) ? NUM_REQ'(1) << grant_q : '0;
  assign fire = tx_valid && tx_ready;
  assign done = fire && req_last[grant_q];
  assign cnt_d = cnt_q + 1'b1;
  assign grant_id = grant_q;
  assign overrun = overrun_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_REQ - 1);
      cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (state_q == IDLE) begin
        if (any) begin
          state_q <= XFER;
          grant_q <= win;
          cnt_q <= '0;
        end
      end else if (fire) begin
        cnt_q <= cnt_d;
        // a last byte landing exactly on the length limit is a clean completion, not an overrun
        if (done || cnt_d == LEN_W'(MAX_MSG_LEN)) begin
          state_q <= IDLE;
          last_q <= grant_q;
          overrun_q <= !done;
        end
      end
    end
  end
`ifdef UART_TX_ARB_STATS_EN
  logic [LEN_W-1:0] msg_q [NUM_REQ];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      msg_q[i] <= rst ? '0 : msg_q[i] + LEN_W'(done && grant_q == GW'(i));
  end
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign msg_count[i*LEN_W +: LEN_W] = msg_q[i];
  end
`else
  assign msg_count = '0;
`endif
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of byte-stream requesters sharing one UART transmitter (legal range 2..8).
REQ-002 SHALL have parameter MAX_MSG_LEN, default 256: maximum bytes per granted message before forced release (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NUM_REQ  marks final byte of a message.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester byte accepted.
REQ-009 SHALL have port tx_valid  output  1  byte valid toward uart_processor transmitter.
REQ-010 SHALL have port tx_data  output  8  byte toward transmitter.
REQ-011 SHALL have port tx_ready  input  1  transmitter accepts byte.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of current owner.
REQ-013 SHALL have port busy  output  1  a message is in progress.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse on forced release.
REQ-015 SHALL have port msg_count  output  16*NUM_REQ  per-requester completed-message counters (see REQ-030).

Function
REQ-016 SHALL implement states IDLE and XFER only.
REQ-017 IDLE: tx_valid=0, req_ready=0, busy=0; if any req_valid=1, SHALL latch winner and enter XFER next cycle (request-to-first-byte latency 1 cycle).
REQ-018 Winner SHALL be round-robin: first asserted req_valid searching from last_grant+1 upward, wrapping NUM_REQ-1 -> 0.
REQ-019 XFER: tx_valid=req_valid[grant_id], tx_data=req_data of grant_id, req_ready[grant_id]=tx_ready, all other req_ready=0; combinational pass-through, no buffering.
REQ-020 Byte transfer SHALL occur only when tx_valid and tx_ready are both 1 in the same cycle.
REQ-021 Transfer with req_last=1 SHALL return to IDLE next cycle and set last_grant=grant_id.
REQ-022 SHALL count transferred bytes per message in a 16-bit counter cleared on entering XFER.
REQ-023 If the MAX_MSG_LEN-th byte transfers with req_last=0, SHALL return to IDLE, pulse overrun for exactly one cycle, and advance last_grant.
REQ-024 grant_id SHALL hold its value in IDLE until the next grant; it is meaningful only while busy=1.
REQ-025 Requester deasserting req_valid mid-message SHALL keep ownership; no timeout.
REQ-026 Non-granted requesters' req_valid changes SHALL have no effect until return to IDLE.
REQ-027 Re-arbitration SHALL never occur in XFER; one idle cycle always separates messages.

Reset
REQ-028 rst=1 SHALL force IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), byte counter=0, overrun=0, busy=0, tx_valid=0, req_ready=0, msg_count=0.
REQ-029 rst asserted mid-message SHALL abandon it without a completion count; the partial byte stream is not flagged.

Configuration
REQ-030 With macro UART_TX_ARB_STATS_EN defined, each msg_count slice SHALL increment (wrapping at 16 bits) on completion via req_last; forced releases SHALL not count.
REQ-031 Without UART_TX_ARB_STATS_EN, msg_count SHALL be constant zero and no counter registers SHALL be synthesised.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the state enum (IDLE, XFER), BYTE_W=8, and LEN_W=16.
REQ-033 Round-robin winner selection SHALL be sub-module rr_arbiter (pure combinational: req vector, last_grant -> winner index, any).

Verification
REQ-034 Reset, then req_valid=01 with 3-byte message 0xA1,0xA2,0xA3(last), tx_ready=1 -> tx_valid rises 1 cycle later; three consecutive bytes; busy falls after 0xA3; msg_count[0]=1 if STATS_EN.
REQ-035 Both requesters hold req_valid=1 continuously with 2-byte messages -> grant sequence 0,1,0,1; one IDLE cycle between messages.
REQ-036 tx_ready toggling 1,0,1,0 during a 4-byte message -> each byte held stable while tx_ready=0; no byte duplicated or lost; other req_ready stays 0.
REQ-037 MAX_MSG_LEN=4, requester 1 sends 6 bytes without last -> 4 bytes forwarded, overrun pulses 1 cycle, msg_count[1] unchanged, requester 0 granted next if requesting.
REQ-038 rst=1 asserted after byte 2 of a 5-byte message -> next cycle all outputs at reset values; following request from requester 1 alone is granted normally.
REQ-039 Build without UART_TX_ARB_STATS_EN, run REQ-035 -> msg_count stays 0.
